vfd_tspi_scanner: RTL and testbench

- Parametrised successor to the fixed Tri-SPI VFD shifter; drives a grayscale VFD dot-matrix module (MN15439A class) over LANES parallel serial data lines plus SCK, BLK, LAT.
- Autonomously scans GRIDS grids at a programmable period and fetches pixel gray codes from graphic RAM through a 1-cycle-latency read port.
- Serialises the pixel field, then the grid-select field, and sequences blank/latch.
- Sits between the GRAM read side and the display pins in top.

---
 rtl/vfd_tspi_scanner.sv | 180 ++++++++++++++++++
 tb/tb_vfd_tspi_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vfd_tspi_scanner.sv
// Grid-scanning Tri-SPI shifter for grayscale VFD dot-matrix modules: fetches pixels, serialises pixel + grid fields, sequences BLK/LAT.
// Optional gradient control pulse output enabled by defining VFD_GCP_EN.
module vfd_tspi_scanner #(
  parameter int unsigned LANES    = 3,
  parameter int unsigned PIX_BITS = 234,
  parameter int unsigned GRIDS    = 52,
  parameter int unsigned PERIOD   = 3840,
  parameter int unsigned LAT_CYC  = 5
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        EN,
  output logic [$clog2(PIX_BITS)-1:0] PIX_IDX,
  output logic [$clog2(GRIDS)-1:0]    GRID_PAIR,
  output logic                        PIX_REQ,
  input  logic [LANES-1:0]            PIX_DATA,
  output logic [LANES-1:0]            SOUT,
  output logic                        SCK,
  output logic                        BLK,
  output logic                        LAT,
  output logic                        GCP,
  output logic                        BUSY
);

  localparam int unsigned BITS = PIX_BITS + GRIDS;
  localparam int unsigned IW   = $clog2(PIX_BITS);
  localparam int unsigned GW   = $clog2(GRIDS);
  localparam int unsigned CW   = $clog2(PERIOD);
  localparam int unsigned BW   = $clog2(BITS);
  localparam int unsigned LW   = $clog2(LAT_CYC + 1);

  if (PERIOD < 2 * BITS + LAT_CYC + 4) begin : g_period_chk
    $error("vfd_tspi_scanner: PERIOD too short to blank, latch and shift one grid");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BLANK, S_LATCH, S_UNBLANK, S_SHIFT, S_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   per_cnt;
  logic [LW-1:0]   lat_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            phase_b;
  logic [GW-1:0]   grid;
  logic            scanned;

  logic            tick_c;
  logic            nxt_pix_c;
  logic            grid_hit_c;
  logic [BW-1:0]   nxt_bit_c;
  logic [BW-1:0]   grid_j_c;

  assign tick_c     = (per_cnt == CW'(PERIOD - 1));
  assign nxt_bit_c  = bit_cnt + BW'(1);
  assign nxt_pix_c  = (nxt_bit_c < BW'(PIX_BITS));
  assign grid_j_c   = nxt_bit_c - BW'(PIX_BITS);
  // Grid field selects the current grid and its successor; the last grid has no successor.
  assign grid_hit_c = (grid_j_c == BW'(grid)) || (grid_j_c == BW'(grid) + BW'(1));
  assign GRID_PAIR  = grid;

`ifdef VFD_GCP_EN
  localparam int unsigned GK0 = 72  * BITS / 288;
  localparam int unsigned GK1 = 144 * BITS / 288;
  localparam int unsigned GK2 = 192 * BITS / 288;
  localparam int unsigned GK3 = 216 * BITS / 288;
  localparam int unsigned GK4 = 240 * BITS / 288;
  localparam int unsigned GK5 = 256 * BITS / 288;

  function automatic logic gcp_hit(input logic [BW-1:0] n);
    return (n == BW'(GK0)) || (n == BW'(GK1)) || (n == BW'(GK2)) ||
           (n == BW'(GK3)) || (n == BW'(GK4)) || (n == BW'(GK5));
  endfunction
`else
  assign GCP = 1'b0;
`endif

  // Free-running grid period counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)       per_cnt <= '0;
    else if (tick_c) per_cnt <= '0;
    else             per_cnt <= per_cnt + CW'(1);
  end

  // Scan sequencer; SCK is a divided register, SOUT changes only in phase A.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      bit_cnt <= '0;
      phase_b <= 1'b0;
      grid    <= '0;
      scanned <= 1'b0;
      PIX_IDX <= '0;
      PIX_REQ <= 1'b0;
      SOUT    <= '0;
      SCK     <= 1'b0;
      BLK     <= 1'b0;
      LAT     <= 1'b0;
      BUSY    <= 1'b0;
`ifdef VFD_GCP_EN
      GCP     <= 1'b0;
`endif
    end else begin
      PIX_REQ <= 1'b0;
`ifdef VFD_GCP_EN
      GCP     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (tick_c && EN) begin
            state   <= S_BLANK;
            BLK     <= 1'b1;
            scanned <= 1'b1;
          end else begin
            BLK <= scanned;
          end
        end
        S_BLANK: begin
          state   <= S_LATCH;
          LAT     <= 1'b1;
          lat_cnt <= '0;
        end
        S_LATCH: begin
          if (lat_cnt == LW'(LAT_CYC - 1)) begin
            state   <= S_UNBLANK;
            LAT     <= 1'b0;
            grid    <= (grid == GW'(GRIDS - 1)) ? '0 : grid + GW'(1);
            PIX_REQ <= 1'b1;
            PIX_IDX <= '0;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_UNBLANK: begin
          state   <= S_SHIFT;
          BLK     <= 1'b0;
          BUSY    <= 1'b1;
          SCK     <= 1'b0;
          SOUT    <= PIX_DATA;
          bit_cnt <= '0;
          phase_b <= 1'b0;
        end
        S_SHIFT: begin
          if (!phase_b) begin
            phase_b <= 1'b1;
            SCK     <= 1'b1;
            if (nxt_pix_c) begin
              PIX_REQ <= 1'b1;
              PIX_IDX <= IW'(nxt_bit_c);
            end
          end else if (bit_cnt == BW'(BITS - 1)) begin
            state   <= S_WAIT;
            phase_b <= 1'b0;
            SCK     <= 1'b0;
            SOUT    <= '0;
            BUSY    <= 1'b0;
          end else begin
            phase_b <= 1'b0;
            SCK     <= 1'b0;
            bit_cnt <= nxt_bit_c;
            SOUT    <= nxt_pix_c ? PIX_DATA : {LANES{grid_hit_c}};
`ifdef VFD_GCP_EN
            GCP     <= gcp_hit(nxt_bit_c);
`endif
          end
        end
        S_WAIT: begin
          if (tick_c) begin
            BLK <= 1'b1;
            if (EN) state <= S_BLANK;
            else    state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfd_tspi_scanner.sv
// Scoreboard bench for vfd_tspi_scanner: stimulus queues expected serial bits and per-period figures, a monitor checks them.
module tb_vfd_tspi_scanner;

  localparam int unsigned LANES    = 3;
  localparam int unsigned PIX_BITS = 234;
  localparam int unsigned GRIDS    = 52;
  localparam int unsigned PERIOD   = 600;
  localparam int unsigned LAT_CYC  = 5;
  localparam int unsigned NBITS    = PIX_BITS + GRIDS;
  localparam int unsigned NPER     = GRIDS + 1;
`ifdef VFD_GCP_EN
  localparam int unsigned GCP_PER  = 6;
`else
  localparam int unsigned GCP_PER  = 0;
`endif

  logic       CLK  = 1'b0;
  logic       RSTn = 1'b0;
  logic       EN   = 1'b0;
  logic [7:0] PIX_IDX;
  logic [5:0] GRID_PAIR;
  logic       PIX_REQ;
  logic [2:0] PIX_DATA;
  logic [2:0] SOUT;
  logic       SCK, BLK, LAT, GCP, BUSY;

  int n_vec  = 0;
  int n_fail = 0;

  logic [2:0] exp_bits[$];
  int         exp_grid[$];

  always #5 CLK = ~CLK;

  // GRAM echo model: gray code = index LSBs, zero when no read is strobed.
  assign PIX_DATA = PIX_REQ ? PIX_IDX[2:0] : 3'b000;

  vfd_tspi_scanner #(
    .LANES(LANES), .PIX_BITS(PIX_BITS), .GRIDS(GRIDS), .PERIOD(PERIOD), .LAT_CYC(LAT_CYC)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .PIX_IDX(PIX_IDX), .GRID_PAIR(GRID_PAIR), .PIX_REQ(PIX_REQ), .PIX_DATA(PIX_DATA),
    .SOUT(SOUT), .SCK(SCK), .BLK(BLK), .LAT(LAT), .GCP(GCP), .BUSY(BUSY)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_idx"},   int'(PIX_IDX),   0);
    check({tag, "_grid_pair"}, int'(GRID_PAIR), 0);
    check({tag, "_pix_req"},   int'(PIX_REQ),   0);
    check({tag, "_sout"},      int'(SOUT),      0);
    check({tag, "_sck"},       int'(SCK),       0);
    check({tag, "_blk"},       int'(BLK),       0);
    check({tag, "_lat"},       int'(LAT),       0);
    check({tag, "_gcp"},       int'(GCP),       0);
    check({tag, "_busy"},      int'(BUSY),      0);
  endtask

  task automatic push_period(input int g);
    for (int i = 0; i < int'(PIX_BITS); i++) exp_bits.push_back(3'(i % 8));
    for (int j = 0; j < int'(GRIDS); j++)
      exp_bits.push_back((j == g || j == g + 1) ? 3'b111 : 3'b000);
    exp_grid.push_back(g);
  endtask

  // Monitor: compares each shifted bit on SCK rise, and per-period figures when BUSY falls.
  initial begin : monitor
    logic       prev_sck, prev_busy, prev_blk, prev_lat;
    logic [2:0] e;
    int         g, sck_n, req_n, gcp_n, blk_run, lat_run, blk_len, lat_len;
    prev_sck = 0; prev_busy = 0; prev_blk = 0; prev_lat = 0;
    sck_n = 0; req_n = 0; gcp_n = 0; blk_run = 0; lat_run = 0; blk_len = 0; lat_len = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_sck = 0; prev_busy = 0; prev_blk = 0; prev_lat = 0;
        sck_n = 0; req_n = 0; gcp_n = 0; blk_run = 0; lat_run = 0; blk_len = 0; lat_len = 0;
        continue;
      end
      if (SCK && !prev_sck) begin
        if (exp_bits.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_bit: got sout=%0d with no bit expected", SOUT);
        end else begin
          e = exp_bits.pop_front();
          check($sformatf("sout_bit%0d", sck_n), int'(SOUT), int'(e));
        end
        sck_n++;
      end
      if (PIX_REQ) req_n++;
      if (GCP) gcp_n++;
      if (BLK) blk_run++;
      else begin
        if (prev_blk) blk_len = blk_run;
        blk_run = 0;
      end
      if (LAT) lat_run++;
      else begin
        if (prev_lat) lat_len = lat_run;
        lat_run = 0;
      end
      if (!BUSY && prev_busy) begin
        if (exp_grid.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_period: got a shift period with none expected");
        end else begin
          g = exp_grid.pop_front();
          check($sformatf("grid%0d_sck_count", g), sck_n, int'(NBITS));
          check($sformatf("grid%0d_req_count", g), req_n, int'(PIX_BITS));
          check($sformatf("grid%0d_blk_len", g),   blk_len, int'(LAT_CYC) + 2);
          check($sformatf("grid%0d_lat_len", g),   lat_len, int'(LAT_CYC));
          check($sformatf("grid%0d_gcp_count", g), gcp_n, int'(GCP_PER));
          check($sformatf("grid%0d_grid_pair", g), int'(GRID_PAIR), g);
          check($sformatf("grid%0d_sout_idle", g), int'(SOUT), 0);
        end
        sck_n = 0; req_n = 0; gcp_n = 0;
      end
      prev_sck  = SCK;
      prev_busy = BUSY;
      prev_blk  = BLK;
      prev_lat  = LAT;
    end
  end

  initial begin : stim
    int n;
    RSTn = 1'b0;
    EN   = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    @(negedge CLK);
    RSTn = 1'b1;

    // Start a scan and pull reset in the middle of the pixel field.
    push_period(1);
    EN = 1'b1;
    n = 0;
    while (!(PIX_REQ && PIX_IDX == 8'd100) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("wait_pix_idx100", int'(n < 2000), 1);
    @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    check_all_zero("mid_shift_reset");
    exp_bits.delete();
    exp_grid.delete();
    @(negedge CLK);
    check_all_zero("mid_shift_reset_next");
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    // Full grid rotation: 1..51, wrap to 0, then 1 again.
    for (int k = 0; k < int'(NPER); k++) push_period((k + 1) % int'(GRIDS));
    n = 0;
    while (exp_grid.size() > 1 && n < int'(NPER * PERIOD) + 2000) begin
      @(negedge CLK);
      n++;
    end
    check("wait_rotation", int'(n < int'(NPER * PERIOD) + 2000), 1);

    // Drop EN mid-shift of the final period; it must still complete.
    n = 0;
    while (!BUSY && n < int'(2 * PERIOD)) begin
      @(negedge CLK);
      n++;
    end
    check("wait_last_busy", int'(n < int'(2 * PERIOD)), 1);
    repeat (50) @(negedge CLK);
    EN = 1'b0;
    n = 0;
    while (exp_grid.size() > 0 && n < int'(2 * PERIOD)) begin
      @(negedge CLK);
      n++;
    end
    check("wait_last_period", int'(n < int'(2 * PERIOD)), 1);
    repeat (PERIOD + 20) @(negedge CLK);
    check("stopped_blk",       int'(BLK),       1);
    check("stopped_sck",       int'(SCK),       0);
    check("stopped_busy",      int'(BUSY),      0);
    check("stopped_lat",       int'(LAT),       0);
    check("stopped_pix_req",   int'(PIX_REQ),   0);
    check("stopped_sout",      int'(SOUT),      0);
    check("stopped_grid_pair", int'(GRID_PAIR), 1);
    check("leftover_bits",     exp_bits.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
